commit_rat: RTL and testbench

Architectural (retirement) register alias table on the commit side of the rename pipeline. It takes up to two in-order committing instructions per cycle and updates the committed arch→phys mapping. It publishes that mapping as the flat `back_rat` vector, which the front rename table copies on flush or done. It also returns each displaced physical register to the free list, and keeps a physical-register in-use mask for free-list rebuild.

---
 rtl/rename_pkg.sv | 41 ++++
 rtl/commit_slot_resolve.sv | 65 ++++++
 rtl/commit_rat.sv | 94 +++++++++
 tb/tb_commit_rat.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-pipeline constants and types.
// Both the front rename table and the commit-side table import this package.
//   ARCH_REGS  - architectural register count
//   PHY_WIDTH  - physical register index width
//   PHY_REGS   - physical register count (2**PHY_WIDTH)
//   phys_idx_t / arch_idx_t - register index types
//   rat_flat_t - flat arch->phys map, entry i at [i*PHY_WIDTH +: PHY_WIDTH]
//   phy_mask_t - one bit per physical register
package rename_pkg;

   localparam int ARCH_REGS  = 32;
   localparam int PHY_WIDTH  = 6;
   localparam int PHY_REGS   = 1 << PHY_WIDTH;
   localparam int ARCH_WIDTH = $clog2(ARCH_REGS);

   typedef logic [PHY_WIDTH-1:0]           phys_idx_t;
   typedef logic [ARCH_WIDTH-1:0]          arch_idx_t;
   typedef logic [ARCH_REGS*PHY_WIDTH-1:0] rat_flat_t;
   typedef logic [PHY_REGS-1:0]            phy_mask_t;

   // Reset map: arch reg i lives in phys reg i.
   function automatic rat_flat_t identity_rat();
      rat_flat_t r;
      r = '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
         r[i*PHY_WIDTH +: PHY_WIDTH] = phys_idx_t'(i);
      end
      return r;
   endfunction

   // Reset in-use mask: exactly the identity-mapped phys regs are live.
   function automatic phy_mask_t identity_mask();
      phy_mask_t m;
      m = '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
         m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/commit_slot_resolve.sv
// commit_slot_resolve: combinational resolution of two in-order commit slots
// against the committed map.
//   map_i        - current committed map
//   valid_i      - bit k = slot k commits (slot 0 older)
//   rd_arch_k_i  - slot k destination arch reg
//   rd_phy_k_i   - slot k destination phys reg
//   map_o        - map after both slots
//   free_en_o    - bit k = slot k displaces a phys reg
//   old_k_o      - phys reg displaced by slot k
//   mask_set_o   - in-use bits to set
//   mask_clr_o   - in-use bits to clear (applied before set)
module commit_slot_resolve
   import rename_pkg::*;
(
   input  rat_flat_t   map_i,
   input  logic [1:0]  valid_i,
   input  arch_idx_t   rd_arch_0_i,
   input  phys_idx_t   rd_phy_0_i,
   input  arch_idx_t   rd_arch_1_i,
   input  phys_idx_t   rd_phy_1_i,
   output rat_flat_t   map_o,
   output logic [1:0]  free_en_o,
   output phys_idx_t   old_0_o,
   output phys_idx_t   old_1_o,
   output phy_mask_t   mask_set_o,
   output phy_mask_t   mask_clr_o
);

   rat_flat_t map_mid;
   phys_idx_t old_0, old_1;
   logic      en_0, en_1;
   phy_mask_t set_0, set_1, clr_0, clr_1;

   always_comb begin
      map_mid = map_i;
      old_0   = map_i[int'(rd_arch_0_i)*PHY_WIDTH +: PHY_WIDTH];
      // x0 writes and rewrites to the same phys reg are no-ops.
      en_0    = valid_i[0] && (rd_arch_0_i != '0) && (rd_phy_0_i != old_0);
      if (en_0) begin
         map_mid[int'(rd_arch_0_i)*PHY_WIDTH +: PHY_WIDTH] = rd_phy_0_i;
      end

      // Slot 1 sees slot 0's result, so a shared rd frees slot 0's phys.
      old_1 = map_mid[int'(rd_arch_1_i)*PHY_WIDTH +: PHY_WIDTH];
      en_1  = valid_i[1] && (rd_arch_1_i != '0) && (rd_phy_1_i != old_1);
      map_o = map_mid;
      if (en_1) begin
         map_o[int'(rd_arch_1_i)*PHY_WIDTH +: PHY_WIDTH] = rd_phy_1_i;
      end

      set_0 = en_0 ? (phy_mask_t'(1) << rd_phy_0_i) : '0;
      clr_0 = en_0 ? (phy_mask_t'(1) << old_0)      : '0;
      set_1 = en_1 ? (phy_mask_t'(1) << rd_phy_1_i) : '0;
      clr_1 = en_1 ? (phy_mask_t'(1) << old_1)      : '0;

      // Sequential apply ((m & ~c0 | s0) & ~c1) | s1 folded into one set/clr
      // pair: slot 0's set bit survives only if slot 1 does not clear it.
      mask_clr_o = clr_0 | clr_1;
      mask_set_o = (set_0 & ~clr_1) | set_1;
      free_en_o  = {en_1, en_0};
      old_0_o    = old_0;
      old_1_o    = old_1;
   end

endmodule

// File: rtl/commit_rat.sv
// commit_rat: retirement register alias table.
// Applies up to two in-order commits per cycle to the committed arch->phys
// map, releases displaced phys regs to the free list (one-cycle pulses, no
// backpressure: the free list must absorb two per cycle), tracks which phys
// regs hold committed mappings and counts retired instructions.
//   clk, rst          - clock, synchronous active-high reset
//   commit_valid      - bit k = slot k commits (slot 0 older)
//   commit_rd_arch_k  - slot k destination arch reg
//   commit_rd_phy_k   - slot k destination phys reg
//   back_rat          - committed map, registered only
//   free_valid        - bit k = free_phy_k released this cycle
//   free_phy_k        - released phys reg
//   phy_in_use        - committed-mapping mask
//   retired_count     - wrapping retired-instruction count
module commit_rat
   import rename_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     commit_valid,
   input  logic [ARCH_WIDTH-1:0]          commit_rd_arch_0,
   input  logic [PHY_WIDTH-1:0]           commit_rd_phy_0,
   input  logic [ARCH_WIDTH-1:0]          commit_rd_arch_1,
   input  logic [PHY_WIDTH-1:0]           commit_rd_phy_1,
   output logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat,
   output logic [1:0]                     free_valid,
   output logic [PHY_WIDTH-1:0]           free_phy_0,
   output logic [PHY_WIDTH-1:0]           free_phy_1,
   output logic [PHY_REGS-1:0]            phy_in_use,
   output logic [31:0]                    retired_count
);

   rat_flat_t   map_q, map_d;
   phy_mask_t   in_use_q, in_use_d;
   logic [1:0]  free_valid_q, free_valid_d;
   phys_idx_t   free_phy_0_q, free_phy_0_d;
   phys_idx_t   free_phy_1_q, free_phy_1_d;
   logic [31:0] retired_count_q, retired_count_d;

   phy_mask_t   mask_set, mask_clr;
   phys_idx_t   old_0, old_1;
   logic [1:0]  free_en;

   commit_slot_resolve u_resolve (
      .map_i       (map_q),
      .valid_i     (commit_valid),
      .rd_arch_0_i (commit_rd_arch_0),
      .rd_phy_0_i  (commit_rd_phy_0),
      .rd_arch_1_i (commit_rd_arch_1),
      .rd_phy_1_i  (commit_rd_phy_1),
      .map_o       (map_d),
      .free_en_o   (free_en),
      .old_0_o     (old_0),
      .old_1_o     (old_1),
      .mask_set_o  (mask_set),
      .mask_clr_o  (mask_clr)
   );

   always_comb begin
      in_use_d        = (in_use_q & ~mask_clr) | mask_set;
      free_valid_d    = free_en;
      free_phy_0_d    = free_en[0] ? old_0 : '0;
      free_phy_1_d    = free_en[1] ? old_1 : '0;
      // x0 commits still retire, so count raw valid bits.
      retired_count_d = retired_count_q + 32'(commit_valid[0])
                                        + 32'(commit_valid[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         map_q           <= identity_rat();
         in_use_q        <= identity_mask();
         free_valid_q    <= '0;
         free_phy_0_q    <= '0;
         free_phy_1_q    <= '0;
         retired_count_q <= '0;
      end else begin
         map_q           <= map_d;
         in_use_q        <= in_use_d;
         free_valid_q    <= free_valid_d;
         free_phy_0_q    <= free_phy_0_d;
         free_phy_1_q    <= free_phy_1_d;
         retired_count_q <= retired_count_d;
      end
   end

   assign back_rat      = map_q;
   assign phy_in_use    = in_use_q;
   assign free_valid    = free_valid_q;
   assign free_phy_0    = free_phy_0_q;
   assign free_phy_1    = free_phy_1_q;
   assign retired_count = retired_count_q;

endmodule

// File: tb/tb_commit_rat.sv
// tb_commit_rat: directed and random commits against a per-slot reference
// model; expected outputs are queued at drive time and checked after the edge.
module tb_commit_rat;
   import rename_pkg::*;

   logic                           clk;
   logic                           rst;
   logic [1:0]                     commit_valid;
   logic [ARCH_WIDTH-1:0]          commit_rd_arch_0, commit_rd_arch_1;
   logic [PHY_WIDTH-1:0]           commit_rd_phy_0, commit_rd_phy_1;
   logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat;
   logic [1:0]                     free_valid;
   logic [PHY_WIDTH-1:0]           free_phy_0, free_phy_1;
   logic [PHY_REGS-1:0]            phy_in_use;
   logic [31:0]                    retired_count;

   commit_rat dut (
      .clk              (clk),
      .rst              (rst),
      .commit_valid     (commit_valid),
      .commit_rd_arch_0 (commit_rd_arch_0),
      .commit_rd_phy_0  (commit_rd_phy_0),
      .commit_rd_arch_1 (commit_rd_arch_1),
      .commit_rd_phy_1  (commit_rd_phy_1),
      .back_rat         (back_rat),
      .free_valid       (free_valid),
      .free_phy_0       (free_phy_0),
      .free_phy_1       (free_phy_1),
      .phy_in_use       (phy_in_use),
      .retired_count    (retired_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [PHY_WIDTH*ARCH_REGS-1:0] rat;
      logic [1:0]                     fv;
      logic [PHY_WIDTH-1:0]           f0;
      logic [PHY_WIDTH-1:0]           f1;
      logic [PHY_REGS-1:0]            use_m;
      logic [31:0]                    cnt;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   logic [PHY_WIDTH-1:0] m_map [ARCH_REGS];
   logic [PHY_REGS-1:0]  m_use;
   logic [31:0]          m_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic model_reset();
      for (int i = 0; i < ARCH_REGS; i++) m_map[i] = PHY_WIDTH'(i);
      m_use = '0;
      for (int i = 0; i < ARCH_REGS; i++) m_use[i] = 1'b1;
      m_cnt = '0;
   endtask

   // Drive one cycle of stimulus, update the model and queue the expectation.
   task automatic step(input logic r, input logic [1:0] v,
                       input int a0, input int p0, input int a1, input int p1);
      exp_t e;
      int a [2];
      int p [2];
      logic [PHY_WIDTH-1:0] old;
      @(negedge clk);
      rst              = r;
      commit_valid     = v;
      commit_rd_arch_0 = ARCH_WIDTH'(a0);
      commit_rd_phy_0  = PHY_WIDTH'(p0);
      commit_rd_arch_1 = ARCH_WIDTH'(a1);
      commit_rd_phy_1  = PHY_WIDTH'(p1);
      a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
      e.fv = '0; e.f0 = '0; e.f1 = '0;
      if (r) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (v[k] && a[k] != 0) begin
               old = m_map[a[k]];
               if (PHY_WIDTH'(p[k]) != old) begin
                  m_map[a[k]] = PHY_WIDTH'(p[k]);
                  m_use[old]  = 1'b0;
                  m_use[p[k]] = 1'b1;
                  e.fv[k]     = 1'b1;
                  if (k == 0) e.f0 = old; else e.f1 = old;
               end
            end
         end
         m_cnt = m_cnt + 32'(v[0]) + 32'(v[1]);
      end
      for (int i = 0; i < ARCH_REGS; i++) e.rat[i*PHY_WIDTH +: PHY_WIDTH] = m_map[i];
      e.use_m = m_use;
      e.cnt   = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 256'(1), 256'(0));
         return;
      end
      e = exp_q.pop_front();
      chk("back_rat", 256'(back_rat), 256'(e.rat));
      chk("free_valid", 256'(free_valid), 256'(e.fv));
      if (e.fv[0]) chk("free_phy_0", 256'(free_phy_0), 256'(e.f0));
      if (e.fv[1]) chk("free_phy_1", 256'(free_phy_1), 256'(e.f1));
      chk("phy_in_use", 256'(phy_in_use), 256'(e.use_m));
      chk("retired_count", 256'(retired_count), 256'(e.cnt));
   endtask

   initial begin
      rst = 1'b1;
      commit_valid = '0;
      commit_rd_arch_0 = '0; commit_rd_phy_0 = '0;
      commit_rd_arch_1 = '0; commit_rd_phy_1 = '0;
      model_reset();

      // reset, then idle
      step(1'b1, 2'b00, 0, 0, 0, 0);
      step(1'b1, 2'b00, 0, 0, 0, 0);
      step(1'b0, 2'b00, 0, 0, 0, 0);
      chk("reset_in_use", 256'(phy_in_use), 256'(64'h0000_0000_FFFF_FFFF));
      chk("reset_map31", 256'(back_rat[31*PHY_WIDTH +: PHY_WIDTH]), 256'(31));
      chk("reset_count", 256'(retired_count), 256'(0));

      // slot 0 rd=5 phy=40
      step(1'b0, 2'b01, 5, 40, 0, 0);
      chk("map5", 256'(back_rat[5*PHY_WIDTH +: PHY_WIDTH]), 256'(40));
      chk("fv_rd5", 256'(free_valid), 256'(2'b01));
      chk("free5", 256'(free_phy_0), 256'(5));
      chk("use40_5", 256'({phy_in_use[40], phy_in_use[5]}), 256'(2'b10));
      chk("count1", 256'(retired_count), 256'(1));

      // idle forces free_valid low
      step(1'b0, 2'b00, 9, 60, 9, 61);

      // same rd in both slots
      step(1'b0, 2'b11, 7, 33, 7, 34);
      chk("map7", 256'(back_rat[7*PHY_WIDTH +: PHY_WIDTH]), 256'(34));
      chk("fv_rd7", 256'(free_valid), 256'(2'b11));
      chk("free7_0", 256'(free_phy_0), 256'(7));
      chk("free7_1", 256'(free_phy_1), 256'(33));
      chk("use_rd7", 256'({phy_in_use[34], phy_in_use[33], phy_in_use[7]}), 256'(3'b100));

      // both slots to x0
      step(1'b0, 2'b11, 0, 50, 0, 51);
      chk("x0_fv", 256'(free_valid), 256'(2'b00));
      chk("x0_count", 256'(retired_count), 256'(5));

      // degenerate slot 0 with normal slot 1
      step(1'b0, 2'b11, 3, 3, 4, 45);
      chk("degen_fv", 256'(free_valid), 256'(2'b10));
      chk("degen_f1", 256'(free_phy_1), 256'(4));
      chk("degen_map3", 256'(back_rat[3*PHY_WIDTH +: PHY_WIDTH]), 256'(3));

      // slot 1 alone, then different rds in both slots
      step(1'b0, 2'b10, 0, 0, 12, 48);
      step(1'b0, 2'b11, 13, 49, 14, 52);

      // random traffic
      for (int n = 0; n < 150; n++) begin
         step(1'b0, 2'($urandom_range(0, 3)),
              $urandom_range(0, ARCH_REGS-1), $urandom_range(0, PHY_REGS-1),
              $urandom_range(0, ARCH_REGS-1), $urandom_range(0, PHY_REGS-1));
      end

      // reset overrides a same-cycle commit
      step(1'b1, 2'b11, 8, 55, 9, 56);
      chk("rst_fv", 256'(free_valid), 256'(2'b00));
      chk("rst_count", 256'(retired_count), 256'(0));
      step(1'b0, 2'b00, 0, 0, 0, 0);

      // preload the counter near wrap, then wrap with 2 and 1 commits
      @(negedge clk);
      force dut.retired_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.retired_count_q;
      m_cnt = 32'hFFFF_FFFE;
      step(1'b0, 2'b11, 0, 1, 0, 2);
      chk("wrap0", 256'(retired_count), 256'(0));
      step(1'b0, 2'b01, 10, 62, 0, 0);
      chk("wrap1", 256'(retired_count), 256'(1));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
